// File: rtl/sgd_add_tree_sched.sv
// Beat sequencer for sgd_dsp_add_tree: masks the tail beat, counts passes
// and accumulates the per-pass tree sums into one wide dot-product result.
module sgd_add_tree_sched #(
    parameter int LANES = 8,
    parameter int LEN_W = 16,
    parameter int ACC_W = 48,
    parameter int CNT_W = 12
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [LEN_W-1:0]         vec_len,
    output logic                     busy,
    input  logic [LANES*32-1:0]      s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic [LANES*32-1:0]      tree_input,
    output logic                     tree_valid,
    output logic [LANES-1:0]         tree_enable,
    input  logic signed [31:0]       tree_output,
    input  logic                     tree_output_valid,
    output logic signed [ACC_W-1:0]  result,
    output logic                     result_valid
);

    typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

    localparam logic [LEN_W-1:0] LANES_L = LEN_W'(LANES);

    state_t                  state_q, state_d;
    logic [LEN_W-1:0]        rem;
    logic signed [ACC_W-1:0] acc;
    logic [CNT_W-1:0]        issued, returned;
    logic                    accept, last_beat, launch, ret_ok;

    assign s_ready   = (state_q == FEED);
    assign busy      = (state_q != IDLE);
    assign accept    = s_valid && s_ready;
    assign last_beat = (rem <= LANES_L);
    assign launch    = (state_q == IDLE) && start;
    // Late returns after a reset land in IDLE and must not disturb acc.
    assign ret_ok    = tree_output_valid && (state_q != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = (vec_len != '0) ? FEED : DONE;
            FEED:    if (accept && last_beat) state_d = DRAIN;
            DRAIN:   if (returned == issued) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem          <= '0;
            acc          <= '0;
            issued       <= '0;
            returned     <= '0;
            tree_valid   <= 1'b0;
            tree_enable  <= '0;
            tree_input   <= '0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            tree_valid   <= accept;
            for (int i = 0; i < LANES; i++) begin
                if (accept && (rem > LEN_W'(i))) begin
                    tree_enable[i]         <= 1'b1;
                    tree_input[i*32 +: 32] <= s_data[i*32 +: 32];
                end else begin
                    tree_enable[i]         <= 1'b0;
                    tree_input[i*32 +: 32] <= '0;
                end
            end
            if (launch) begin
                rem      <= vec_len;
                acc      <= '0;
                issued   <= '0;
                returned <= '0;
            end else begin
                if (accept) begin
                    rem    <= last_beat ? '0 : rem - LANES_L;
                    issued <= issued + 1'b1;
                end
                if (ret_ok) begin
                    acc      <= acc + ACC_W'(tree_output);
                    returned <= returned + 1'b1;
                end
            end
            if (state_q == DONE) begin
                result       <= acc;
                result_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sgd_add_tree_sched.sv
// Scoreboard bench for sgd_add_tree_sched with a small latency-3 tree model.
module tb_sgd_add_tree_sched;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic [15:0]        vec_len;
    logic               busy;
    logic [255:0]       s_data;
    logic               s_valid;
    logic               s_ready;
    logic [255:0]       tree_input;
    logic               tree_valid;
    logic [7:0]         tree_enable;
    logic signed [31:0] tree_output;
    logic               tree_output_valid;
    logic signed [47:0] result;
    logic               result_valid;

    sgd_add_tree_sched dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .vec_len           (vec_len),
        .busy              (busy),
        .s_data            (s_data),
        .s_valid           (s_valid),
        .s_ready           (s_ready),
        .tree_input        (tree_input),
        .tree_valid        (tree_valid),
        .tree_enable       (tree_enable),
        .tree_output       (tree_output),
        .tree_output_valid (tree_output_valid),
        .result            (result),
        .result_valid      (result_valid)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int tv_cnt = 0;
    int rv_cnt = 0;
    int rv_cyc = 0;

    logic signed [47:0] exp_q[$];
    logic [7:0]         en_q[$];
    logic [255:0]       din_q[$];

    bit                 auto_tree = 1'b1;
    bit                 sat_tree = 1'b0;
    bit                 pv[3];
    logic signed [31:0] pd[3];

    task automatic chk(input string tag, input logic [255:0] got,
                       input logic [255:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic clear_pipe();
        for (int i = 0; i < 3; i++) begin
            pv[i] = 1'b0;
            pd[i] = '0;
        end
    endtask

    task automatic tick();
        logic [31:0] sm;
        @(posedge clk);
        #1;
        cyc++;
        if (tree_valid) begin
            tv_cnt++;
            chk("en_q_nonempty", 256'(en_q.size() != 0), 256'(1));
            if (en_q.size() != 0) begin
                chk("tree_enable", 256'(tree_enable), 256'(en_q.pop_front()));
                chk("tree_input", tree_input, din_q.pop_front());
            end
        end
        if (result_valid) begin
            rv_cnt++;
            rv_cyc = cyc;
            chk("exp_q_nonempty", 256'(exp_q.size() != 0), 256'(1));
            if (exp_q.size() != 0)
                chk("result", 256'(result), 256'(exp_q.pop_front()));
            chk("busy_at_rv", 256'(busy), 256'(0));
        end
        if (auto_tree) begin
            sm = '0;
            for (int i = 0; i < 8; i++) sm += tree_input[i*32 +: 32];
            tree_output_valid = pv[2];
            tree_output       = pd[2];
            pv[2] = pv[1];  pd[2] = pd[1];
            pv[1] = pv[0];  pd[1] = pd[0];
            pv[0] = tree_valid;
            pd[0] = sat_tree ? 32'sh7FFFFFFF : $signed(sm);
        end
    endtask

    function automatic logic [255:0] make_beat(int b, int mode);
        logic [255:0] d;
        for (int i = 0; i < 8; i++) begin
            case (mode)
                0:       d[i*32 +: 32] = 32'(b * 8 + i + 1);
                1:       d[i*32 +: 32] = 32'd2;
                default: d[i*32 +: 32] = 32'h7FFFFFFF;
            endcase
        end
        return d;
    endfunction

    task automatic push_beat(int rem, logic [255:0] d);
        logic [7:0]   m;
        logic [255:0] md;
        md = '0;
        for (int i = 0; i < 8; i++) begin
            m[i] = (i < rem);
            if (m[i]) md[i*32 +: 32] = d[i*32 +: 32];
        end
        en_q.push_back(m);
        din_q.push_back(md);
    endtask

    task automatic start_vec(int len);
        start   = 1'b1;
        vec_len = 16'(len);
        tick();
        start = 1'b0;
        chk("busy_rise", 256'(busy), 256'(1));
    endtask

    task automatic feed(int len, int mode);
        int rem;
        int b;
        int guard;
        logic [255:0] d;
        rem = len;
        b = 0;
        guard = 0;
        while (rem > 0 && guard < 20000) begin
            d = make_beat(b, mode);
            s_data  = d;
            s_valid = 1'b1;
            if (s_ready) begin
                push_beat(rem, d);
                rem -= (rem < 8) ? rem : 8;
                b++;
            end
            tick();
            guard++;
        end
        s_valid = 1'b0;
        chk("feed_done", 256'(rem), 256'(0));
    endtask

    task automatic wait_result();
        int r0;
        r0 = rv_cnt;
        for (int k = 0; k < 200 && rv_cnt == r0; k++) tick();
        chk("result_seen", 256'(rv_cnt - r0), 256'(1));
    endtask

    task automatic run_vec(int len, int mode, logic signed [47:0] want);
        start_vec(len);
        exp_q.push_back(want);
        feed(len, mode);
        wait_result();
    endtask

    initial begin
        int tv0, rv0, c0;
        logic [255:0] d;
        rst_n = 1'b0;
        start = 1'b0;
        vec_len = '0;
        s_data = '0;
        s_valid = 1'b0;
        tree_output = '0;
        tree_output_valid = 1'b0;
        clear_pipe();
        tick();
        tick();
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_s_ready", 256'(s_ready), 256'(0));
        chk("rst_tree_valid", 256'(tree_valid), 256'(0));
        chk("rst_tree_enable", 256'(tree_enable), 256'(0));
        chk("rst_result", 256'(result), 256'(0));
        chk("rst_result_valid", 256'(result_valid), 256'(0));
        rst_n = 1'b1;
        tick();

        // one full beat, elements 1..8
        tv0 = tv_cnt;
        rv0 = rv_cnt;
        run_vec(8, 0, 48'sd36);
        tick();
        chk("t1_busy_after", 256'(busy), 256'(0));
        chk("t1_tree_passes", 256'(tv_cnt - tv0), 256'(1));
        chk("t1_rv_once", 256'(rv_cnt - rv0), 256'(1));

        // partial tail beat, excess lanes driven non-zero
        tv0 = tv_cnt;
        run_vec(19, 1, 48'sd38);
        chk("t2_tree_passes", 256'(tv_cnt - tv0), 256'(3));
        tick();

        // gapped input with returns injected by hand
        auto_tree = 1'b0;
        start_vec(16);
        d = make_beat(0, 0);
        s_data = d;
        s_valid = 1'b1;
        chk("t3_ready0", 256'(s_ready), 256'(1));
        push_beat(16, d);
        tick();
        s_valid = 1'b0;
        tick();
        d = make_beat(1, 0);
        s_data = d;
        s_valid = 1'b1;
        chk("t3_ready1", 256'(s_ready), 256'(1));
        push_beat(8, d);
        tree_output_valid = 1'b1;
        tree_output = -32'sd5;
        tick();
        s_valid = 1'b0;
        tree_output = 32'sd100;
        tick();
        tree_output_valid = 1'b0;
        tick();
        chk("t3_ready_low", 256'(s_ready), 256'(0));
        exp_q.push_back(48'sd95);
        wait_result();
        clear_pipe();
        auto_tree = 1'b1;
        tick();

        // empty vector
        tv0 = tv_cnt;
        exp_q.push_back(48'sd0);
        start_vec(0);
        c0 = cyc;
        wait_result();
        chk("t4_latency", 256'(rv_cyc - c0), 256'(1));
        chk("t4_no_pass", 256'(tv_cnt - tv0), 256'(0));
        tick();

        // start while busy must be ignored
        start_vec(8);
        exp_q.push_back(48'sd36);
        feed(8, 0);
        start = 1'b1;
        vec_len = 16'd3;
        tick();
        start = 1'b0;
        wait_result();
        rv0 = rv_cnt;
        for (int k = 0; k < 6; k++) tick();
        chk("t4_busy_idle", 256'(busy), 256'(0));
        chk("t4_no_extra_rv", 256'(rv_cnt - rv0), 256'(0));

        // reset in DRAIN with one return outstanding
        auto_tree = 1'b0;
        start_vec(16);
        feed(16, 0);
        tree_output_valid = 1'b1;
        tree_output = 32'sd10;
        tick();
        tree_output_valid = 1'b0;
        tick();
        chk("t5_draining", 256'(busy), 256'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_busy", 256'(busy), 256'(0));
        chk("t5_s_ready", 256'(s_ready), 256'(0));
        chk("t5_tree_valid", 256'(tree_valid), 256'(0));
        chk("t5_tree_enable", 256'(tree_enable), 256'(0));
        chk("t5_result", 256'(result), 256'(0));
        chk("t5_result_valid", 256'(result_valid), 256'(0));
        tick();
        rst_n = 1'b1;
        tick();
        tree_output_valid = 1'b1;
        tree_output = 32'sd77;
        tick();
        tree_output_valid = 1'b0;
        tick();
        tick();
        chk("t5_idle", 256'(busy), 256'(0));
        chk("t5_result_hold", 256'(result), 256'(0));
        clear_pipe();
        auto_tree = 1'b1;
        run_vec(8, 0, 48'sd36);
        tick();

        // long vector: wide accumulation beyond 32 bits
        sat_tree = 1'b1;
        tv0 = tv_cnt;
        run_vec(4096, 2, 48'(64'd512 * 64'h7FFFFFFF));
        chk("t6_tree_passes", 256'(tv_cnt - tv0), 256'(512));
        sat_tree = 1'b0;
        tick();

        chk("exp_q_drained", 256'(exp_q.size()), 256'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
